// File: rtl/mips_pkg.sv
// Shared types and constants for the mips data-bus peripherals.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } timer_state_t;

  localparam logic [1:0] TIMER_CTRL   = 2'd0;
  localparam logic [1:0] TIMER_PRESET = 2'd1;
  localparam logic [1:0] TIMER_COUNT  = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  // Replace only the byte lanes whose enable bit is set.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  byteen);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (byteen[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer on the core data bus.
//
// state | meaning
// IDLE  | stopped, waiting for CTRL.EN
// LOAD  | copy PRESET into COUNT, clear irq_flag
// CNT   | count down while EN stays set
// INT   | count expired; reload or stop depending on MODE
module timer_dev
  import mips_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
  parameter int          WIDTH     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic [3:0]       byteen,
  output logic [31:0]      rdata,
  output logic             hit,
  output logic             irq
);

  timer_state_t     state, state_nxt;
  logic [3:0]       ctrl;
  logic [WIDTH-1:0] preset;
  logic [WIDTH-1:0] count;
  logic             irq_flag;

  logic [1:0]  offset;
  logic        wr_en;
  logic        ctrl_wr;
  logic        preset_wr;
  logic        en;
  logic [1:0]  mode;
  logic        expire;
  logic [31:0] ctrl_merged;

  assign offset      = addr[3:2];
  assign en          = ctrl[CTRL_EN];
  assign mode        = ctrl[CTRL_MODE_LO +: 2];
  assign wr_en       = hit && (byteen != 4'b0000);
  assign ctrl_wr     = wr_en && (offset == TIMER_CTRL);
  assign preset_wr   = wr_en && (offset == TIMER_PRESET);
  assign expire      = (state == CNT) && en && (count <= WIDTH'(1));
  assign ctrl_merged = byte_merge({28'd0, ctrl}, wdata, byteen);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; only MODE=01 reloads, every other mode is one-shot.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (en) state_nxt = LOAD;
      LOAD: state_nxt = CNT;
      CNT: begin
        if (!en)        state_nxt = IDLE;
        else if (expire) state_nxt = INT;
      end
      INT:  state_nxt = (mode == MODE_RELOAD) ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus outputs and interrupt.
  always_comb begin
    hit   = (addr[31:4] == BASE_ADDR[31:4]) && (offset != 2'b11);
    rdata = 32'd0;
    if (hit) begin
      unique case (offset)
        TIMER_CTRL:   rdata = {28'd0, ctrl};
        TIMER_PRESET: rdata = 32'(preset);
        TIMER_COUNT:  rdata = 32'(count);
        default:      rdata = 32'd0;
      endcase
    end
    irq = irq_flag && ctrl[CTRL_IM];
  end

  // Registers; a software EN write in the INT cycle overrides the hardware clear,
  // and an expiry in the same cycle as a CTRL write still raises the flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl     <= 4'd0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        ctrl <= ctrl_merged[3:0];
      end else if ((state == INT) && (mode != MODE_RELOAD)) begin
        ctrl[CTRL_EN] <= 1'b0;
      end

      if (preset_wr) preset <= WIDTH'(byte_merge(32'(preset), wdata, byteen));

      if (state == LOAD) begin
        count <= preset;
      end else if ((state == CNT) && en) begin
        count <= (count > WIDTH'(1)) ? count - WIDTH'(1) : '0;
      end

      if (expire) begin
        irq_flag <= 1'b1;
      end else if (ctrl_wr || (state == LOAD) || ((state == INT) && (mode == MODE_RELOAD))) begin
        irq_flag <= 1'b0;
      end
    end
  end

endmodule
